// File: rtl/pwm_ramp_ctrl_if.sv
// rtl/pwm_ramp_ctrl_if.sv - target command channel for the PWM duty ramp controller
interface pwm_ramp_ctrl_if #(
  parameter int DW = 8
);
  logic          tgt_valid;
  logic          tgt_ready;
  logic [DW-1:0] tgt_duty;
  logic [DW-1:0] step_size;
  logic [DW-1:0] step_periods;

  modport master (
    output tgt_valid,
    output tgt_duty,
    output step_size,
    output step_periods,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_duty,
    input  step_size,
    input  step_periods,
    output tgt_ready
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - frame-aligned soft-start duty sequencer with emergency stop
module pwm_ramp_ctrl #(
  parameter int DW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  pwm_ramp_ctrl_if.slave cmd,
  input  logic           i_estop,
  output logic [DW-1:0]  o_duty,
  output logic           o_frame_start,
  output logic           o_busy,
  output logic           o_at_target
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [DW-1:0] r_frame_cnt;
  logic [DW-1:0] r_duty;
  logic [DW-1:0] r_tgt;
  logic [DW-1:0] r_step;
  logic [DW-1:0] r_per;
  logic [DW-1:0] r_per_cnt;

  logic          w_wrap;
  logic          w_ready;
  logic          w_accept;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW-1:0] w_next;

  assign w_wrap   = (r_frame_cnt == {DW{1'b1}});
  // estop masks ready, so a command arriving with estop is never accepted
  assign w_ready  = ((r_state == ST_IDLE) || (r_state == ST_HOLD)) && !i_estop;
  assign w_accept = cmd.tgt_valid && w_ready;

  assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
  assign w_diff = {1'b0, r_duty} - {1'b0, r_step};

  // One step toward the target, clamped so it never overshoots or wraps
  always_comb begin
    w_next = r_tgt;
    if (r_tgt > r_duty) begin
      if (w_sum < {1'b0, r_tgt}) begin
        w_next = w_sum[DW-1:0];
      end
    end else begin
      if (!w_diff[DW] && (w_diff > {1'b0, r_tgt})) begin
        w_next = w_diff[DW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_frame_cnt <= '0;
      r_duty      <= '0;
      r_tgt       <= '0;
      r_step      <= ONE;
      r_per       <= '0;
      r_per_cnt   <= '0;
    end else begin
      r_frame_cnt <= r_frame_cnt + ONE;
      if (i_estop) begin
        r_state   <= ST_STOP;
        r_duty    <= '0;
        r_per_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE, ST_HOLD: begin
            if (w_accept) begin
              r_tgt     <= cmd.tgt_duty;
              r_step    <= (cmd.step_size == '0) ? ONE : cmd.step_size;
              r_per     <= cmd.step_periods;
              r_per_cnt <= '0;
              r_state   <= (cmd.tgt_duty == r_duty) ? ST_HOLD : ST_RAMP;
            end
          end
          ST_RAMP: begin
            // Duty moves only on the last clock of a frame so the PWM sees it whole
            if (w_wrap) begin
              if (r_per_cnt == r_per) begin
                r_duty    <= w_next;
                r_per_cnt <= '0;
                if (w_next == r_tgt) begin
                  r_state <= ST_HOLD;
                end
              end else begin
                r_per_cnt <= r_per_cnt + ONE;
              end
            end
          end
          ST_STOP: begin
            if (w_wrap) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd.tgt_ready = w_ready;
  assign o_duty        = r_duty;
  assign o_frame_start = (r_frame_cnt == '0);
  assign o_busy        = (r_state == ST_RAMP);
  assign o_at_target   = (r_state == ST_HOLD) && (r_duty == r_tgt);

endmodule
